// File: rtl/cdb_arbiter.sv
// Common data bus arbiter. Two result sources (arith, load/store) each feed a
// small circular FIFO. One queued result per ready cycle is granted onto a
// registered broadcast bus. When both queues hold entries, they alternate
// round-robin. A misbranch flushes every queued result.
//
// Handshake: a source presents valid with a non-zero rob_id. The entry is
// accepted at the rising edge when rdy=1 and that source's full flag is low.
// A source that sees full must hold its entry and retry; an offer made while
// full is silently dropped. The bus has no back-pressure. cdb_valid is high
// for exactly one rdy=1 cycle per accepted entry.
module cdb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int ROB_ID_W   = 4,
  parameter int DATA_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                valid_from_arith,
  input  logic [ROB_ID_W-1:0] rob_id_from_arith,
  input  logic [DATA_W-1:0]   result_from_arith,
  input  logic                valid_from_ls,
  input  logic [ROB_ID_W-1:0] rob_id_from_ls,
  input  logic [DATA_W-1:0]   result_from_ls,
  input  logic                misbranch_flag,
  output logic                full_to_arith,
  output logic                full_to_ls,
  output logic                cdb_valid,
  output logic [ROB_ID_W-1:0] cdb_rob_id,
  output logic [DATA_W-1:0]   cdb_result
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  // Index 0 is the arith source, index 1 is the load/store source.
  typedef enum logic {
    PRIO_ARITH = 1'b0,
    PRIO_LS    = 1'b1
  } prio_t;

  logic [ROB_ID_W-1:0] id_mem   [2][FIFO_DEPTH];
  logic [DATA_W-1:0]   data_mem [2][FIFO_DEPTH];
  logic [PTR_W-1:0]    head     [2];
  logic [PTR_W-1:0]    tail     [2];
  logic [CNT_W-1:0]    count    [2];
  prio_t               prio;

  logic                src_valid [2];
  logic [ROB_ID_W-1:0] src_id    [2];
  logic [DATA_W-1:0]   src_data  [2];
  logic [1:0]          push;
  logic [1:0]          pop;
  logic [1:0]          full;
  logic [1:0]          not_empty;
  logic                gsel;
  logic [ROB_ID_W-1:0] head_id;
  logic [DATA_W-1:0]   head_data;

  // Source bundling, acceptance and round-robin grant, all from pre-edge state.
  always_comb begin
    src_valid[0] = valid_from_arith;
    src_id[0]    = rob_id_from_arith;
    src_data[0]  = result_from_arith;
    src_valid[1] = valid_from_ls;
    src_id[1]    = rob_id_from_ls;
    src_data[1]  = result_from_ls;
    push         = '0;
    full         = '0;
    not_empty    = '0;
    for (int s = 0; s < 2; s++) begin
      full[s]      = (count[s] == CNT_FULL);
      not_empty[s] = (count[s] != CNT_ZERO);
      // A zero id means "no producer" and is never queued.
      push[s]      = rdy && src_valid[s] && (src_id[s] != '0) && !full[s];
    end
    pop    = '0;
    pop[0] = rdy && not_empty[0] && (!not_empty[1] || prio == PRIO_ARITH);
    pop[1] = rdy && not_empty[1] && !pop[0];
    gsel      = pop[1];
    head_id   = id_mem[gsel][head[gsel]];
    head_data = data_mem[gsel][head[gsel]];
  end

  assign full_to_arith = full[0];
  assign full_to_ls    = full[1];

  // Queue storage. A write at a flush/reset edge is harmless because the
  // pointers are cleared at that same edge.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        id_mem[s][tail[s]]   <= src_id[s];
        data_mem[s][tail[s]] <= src_data[s];
      end
    end
  end

  // Pointers, occupancy, priority and the registered broadcast bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        head[s]  <= '0;
        tail[s]  <= '0;
        count[s] <= '0;
      end
      prio       <= PRIO_ARITH;
      cdb_valid  <= 1'b0;
      cdb_rob_id <= '0;
      cdb_result <= '0;
    end else if (misbranch_flag) begin
      // Flush discards queued and in-flight pushes but keeps fairness state.
      for (int s = 0; s < 2; s++) begin
        head[s]  <= '0;
        tail[s]  <= '0;
        count[s] <= '0;
      end
      cdb_valid <= 1'b0;
    end else if (rdy) begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) tail[s] <= tail[s] + 1'b1;
        if (pop[s])  head[s] <= head[s] + 1'b1;
        if (push[s] && !pop[s])      count[s] <= count[s] + CNT_ONE;
        else if (pop[s] && !push[s]) count[s] <= count[s] - CNT_ONE;
      end
      if (pop != 2'b00) begin
        cdb_valid  <= 1'b1;
        cdb_rob_id <= head_id;
        cdb_result <= head_data;
        prio       <= pop[0] ? PRIO_LS : PRIO_ARITH;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vectors, a driver-side reference queue
// model feeding an expected queue, and a monitor that checks every broadcast.
module tb_cdb_arbiter;

  localparam int DEPTH = 4;
  localparam int IW    = 4;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rdy = 1'b0;
  logic          valid_from_arith = 1'b0;
  logic [IW-1:0] rob_id_from_arith = '0;
  logic [DW-1:0] result_from_arith = '0;
  logic          valid_from_ls = 1'b0;
  logic [IW-1:0] rob_id_from_ls = '0;
  logic [DW-1:0] result_from_ls = '0;
  logic          misbranch_flag = 1'b0;
  logic          full_to_arith;
  logic          full_to_ls;
  logic          cdb_valid;
  logic [IW-1:0] cdb_rob_id;
  logic [DW-1:0] cdb_result;

  int errors = 0;
  int checks = 0;

  logic [IW+DW-1:0] exp_q [$];
  logic [IW+DW-1:0] qa [$];
  logic [IW+DW-1:0] ql [$];
  logic             m_prio = 1'b0;
  logic [IW-1:0]    seen_q [$];
  logic [IW-1:0]    ev [16];

  cdb_arbiter #(.FIFO_DEPTH(DEPTH), .ROB_ID_W(IW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .valid_from_arith(valid_from_arith), .rob_id_from_arith(rob_id_from_arith),
    .result_from_arith(result_from_arith),
    .valid_from_ls(valid_from_ls), .rob_id_from_ls(rob_id_from_ls),
    .result_from_ls(result_from_ls),
    .misbranch_flag(misbranch_flag),
    .full_to_arith(full_to_arith), .full_to_ls(full_to_ls),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_result(cdb_result)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] dat(input logic src, input logic [IW-1:0] id);
    return {(src ? 8'h5A : 8'hA5), 20'h0, id};
  endfunction

  // Driver: apply one cycle of inputs, advance the reference model at the edge.
  task automatic step(input logic i_rst, input logic i_rdy, input logic i_mis,
                      input logic i_va, input logic [IW-1:0] i_ida, input logic [DW-1:0] i_da,
                      input logic i_vl, input logic [IW-1:0] i_idl, input logic [DW-1:0] i_dl);
    int  na;
    int  nl;
    logic ga;
    logic gl;
    @(negedge clk);
    rst = i_rst; rdy = i_rdy; misbranch_flag = i_mis;
    valid_from_arith = i_va; rob_id_from_arith = i_ida; result_from_arith = i_da;
    valid_from_ls = i_vl; rob_id_from_ls = i_idl; result_from_ls = i_dl;
    @(posedge clk);
    if (i_rst) begin
      qa.delete(); ql.delete(); m_prio = 1'b0;
    end else if (i_mis) begin
      qa.delete(); ql.delete();
    end else if (i_rdy) begin
      na = qa.size();
      nl = ql.size();
      ga = (na > 0) && ((nl == 0) || (m_prio == 1'b0));
      gl = (nl > 0) && !ga;
      if (ga) begin
        exp_q.push_back(qa.pop_front());
        m_prio = 1'b1;
      end else if (gl) begin
        exp_q.push_back(ql.pop_front());
        m_prio = 1'b0;
      end
      if (i_va && i_ida != '0 && na < DEPTH) qa.push_back({i_ida, i_da});
      if (i_vl && i_idl != '0 && nl < DEPTH) ql.push_back({i_idl, i_dl});
    end
    #1;
    chk("full_arith", full_to_arith, qa.size() == DEPTH);
    chk("full_ls", full_to_ls, ql.size() == DEPTH);
  endtask

  task automatic do_reset();
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push_both(input logic [IW-1:0] ia, input logic [IW-1:0] il);
    step(0, 1, 0, 1, ia, dat(0, ia), 1, il, dat(1, il));
  endtask

  task automatic chk_seq(input string name, input int n);
    chk({name, "_len"}, seen_q.size(), n);
    for (int i = 0; i < n && i < seen_q.size(); i++) chk(name, seen_q[i], ev[i]);
  endtask

  // Monitor: classify each edge, then check outputs on the following negedge.
  initial begin
    logic          e_rst, e_mis, e_rdy;
    logic          p_v;
    logic [IW-1:0] p_id;
    logic [DW-1:0] p_res;
    logic [IW+DW-1:0] e;
    p_v = 1'b0; p_id = '0; p_res = '0;
    forever begin
      @(posedge clk);
      e_rst = rst; e_mis = misbranch_flag; e_rdy = rdy;
      @(negedge clk);
      if (e_rst) begin
        chk("rst_valid", cdb_valid, 0);
        chk("rst_id", cdb_rob_id, 0);
        chk("rst_result", cdb_result, 0);
      end else if (e_mis) begin
        chk("flush_valid", cdb_valid, 0);
      end else if (!e_rdy) begin
        chk("stall_valid", cdb_valid, p_v);
        chk("stall_id", cdb_rob_id, p_id);
        chk("stall_result", cdb_result, p_res);
      end else if (cdb_valid) begin
        seen_q.push_back(cdb_rob_id);
        if (exp_q.size() == 0) begin
          chk("unexpected_bcast", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("bcast", {cdb_rob_id, cdb_result}, e);
        end
      end else begin
        chk("idle_hold_id", cdb_rob_id, p_id);
        chk("idle_hold_result", cdb_result, p_res);
      end
      p_v = cdb_valid; p_id = cdb_rob_id; p_res = cdb_result;
    end
  end

  // Directed sequence
  initial begin
    do_reset();
    do_reset();
    chk("reset_valid", cdb_valid, 0);
    chk("reset_id", cdb_rob_id, 0);
    chk("reset_result", cdb_result, 0);
    chk("reset_full_a", full_to_arith, 0);
    chk("reset_full_l", full_to_ls, 0);

    // Single push, two-edge latency.
    step(0, 1, 0, 1, 4'd3, 32'h11, 0, 0, 0);
    chk("single_e1_valid", cdb_valid, 0);
    idle(1);
    chk("single_e2_valid", cdb_valid, 1);
    chk("single_e2_id", cdb_rob_id, 3);
    chk("single_e2_result", cdb_result, 32'h11);
    idle(1);
    chk("single_e3_valid", cdb_valid, 0);
    chk("single_e3_hold", cdb_rob_id, 3);

    // Contention: strict alternation, no gaps.
    do_reset();
    seen_q.delete();
    push_both(1, 5);
    push_both(2, 6);
    push_both(3, 7);
    idle(5);
    ev = '{1, 5, 2, 6, 3, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_seq("contention", 6);

    // Overflow: both sources push every cycle until the queues fill.
    do_reset();
    seen_q.delete();
    for (int i = 1; i <= 6; i++) push_both(4'(i), 4'(i + 7));
    chk("ovf_full_ls_e6", full_to_ls, 1);
    chk("ovf_full_a_e6", full_to_arith, 0);
    push_both(4'd7, 4'd14);
    chk("ovf_full_a_e7", full_to_arith, 1);
    chk("ovf_full_ls_e7", full_to_ls, 0);
    idle(10);
    ev = '{1, 8, 2, 9, 3, 10, 4, 11, 5, 12, 6, 13, 7, 0, 0, 0};
    chk_seq("overflow", 13);

    // Stall: rdy low freezes everything and ignores pushes.
    do_reset();
    seen_q.delete();
    push_both(1, 2);
    step(0, 1, 0, 1, 4'd3, dat(0, 3), 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 4'd9, dat(0, 9), 1, 4'd9, dat(1, 9));
      chk("stall_valid_hi", cdb_valid, 1);
      chk("stall_id_1", cdb_rob_id, 1);
    end
    idle(4);
    ev = '{1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_seq("stall", 3);

    // Misbranch flush with a simultaneous push; priority survives the flush.
    do_reset();
    seen_q.delete();
    push_both(1, 2);
    step(0, 1, 0, 1, 4'd3, dat(0, 3), 0, 0, 0);
    step(0, 1, 1, 1, 4'd4, dat(0, 4), 1, 4'd5, dat(1, 5));
    chk("mis_valid", cdb_valid, 0);
    idle(3);
    push_both(6, 7);
    idle(4);
    ev = '{1, 7, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_seq("misbranch", 3);

    // ZERO_ROB is never queued; reset with full queues discards everything.
    do_reset();
    seen_q.delete();
    step(0, 1, 0, 1, 4'd0, 32'hDEAD, 0, 0, 0);
    idle(3);
    for (int i = 1; i <= 7; i++) push_both(4'(i), 4'(i + 7));
    step(1, 1, 0, 1, 4'd5, dat(0, 5), 1, 4'd6, dat(1, 6));
    chk("rst_mid_valid", cdb_valid, 0);
    chk("rst_mid_id", cdb_rob_id, 0);
    chk("rst_mid_result", cdb_result, 0);
    chk("rst_mid_full_a", full_to_arith, 0);
    chk("rst_mid_full_l", full_to_ls, 0);
    idle(4);
    ev = '{1, 8, 2, 9, 3, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_seq("zero_rst", 6);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
